// File: rtl/sar_adc_scan.sv
// Successive-approximation ADC sequencer: scans the channels enabled in a mask
// through one shared sample switch, cap DAC and comparator, tagging each result.
module sar_adc_scan #(
   parameter int Bits         = 6,
   parameter int ChanBits     = 2,
   parameter int SampleCycles = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                continuous,
   input  logic [2**ChanBits-1:0] chan_mask,
   input  logic                comp,
   output logic                sample,
   output logic [ChanBits-1:0] channel,
   output logic [Bits-1:0]     trial,
   output logic [Bits-1:0]     result,
   output logic [ChanBits-1:0] result_chan,
   output logic                valid,
   output logic                busy,
   output logic                done
);
   localparam int NCH = 2**ChanBits;
   localparam int CW  = $clog2(SampleCycles + 1);
   localparam int BW  = $clog2(Bits + 1);

   typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT} state_t;

   state_t          state_reg;
   logic [NCH-1:0]  mask_reg;
   logic [CW-1:0]   cnt_reg;
   logic [BW-1:0]   bit_reg;
   logic [NCH-1:0]  above;
   logic [Bits-1:0] onehot;
   logic [Bits-1:0] trial_next;

   // Enabled channels strictly above the one currently being converted.
   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_above
         assign above[gi] = mask_reg[gi] && (ChanBits'(gi) > channel);
      end
   endgenerate

   function automatic logic [ChanBits-1:0] lowest_bit(input logic [NCH-1:0] v);
      lowest_bit = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (v[i]) lowest_bit = ChanBits'(i);
      end
   endfunction

   // Drop the bit under test if the DAC overshot, then arm the next lower bit.
   always_comb begin
      onehot     = Bits'(1) << bit_reg;
      trial_next = (comp ? (trial & ~onehot) : trial) | (onehot >> 1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         mask_reg    <= '0;
         cnt_reg     <= '0;
         bit_reg     <= '0;
         sample      <= 1'b0;
         channel     <= '0;
         trial       <= '0;
         result      <= '0;
         result_chan <= '0;
         valid       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start && (chan_mask != '0)) begin
                  mask_reg  <= chan_mask;
                  channel   <= lowest_bit(chan_mask);
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  sample    <= 1'b1;
                  cnt_reg   <= '0;
                  state_reg <= SAMPLE;
               end
            end
            SAMPLE: begin
               if (cnt_reg == CW'(SampleCycles - 1)) begin
                  sample    <= 1'b0;
                  trial     <= {1'b1, {(Bits-1){1'b0}}};
                  bit_reg   <= BW'(Bits - 1);
                  state_reg <= CONVERT;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            CONVERT: begin
               if (bit_reg != '0) begin
                  trial   <= trial_next;
                  bit_reg <= bit_reg - BW'(1);
               end else begin
                  result      <= trial_next;
                  result_chan <= channel;
                  valid       <= 1'b1;
                  trial       <= '0;
                  if (above != '0) begin
                     channel   <= lowest_bit(above);
                     sample    <= 1'b1;
                     cnt_reg   <= '0;
                     state_reg <= SAMPLE;
                  end else if (continuous && (chan_mask != '0)) begin
                     mask_reg  <= chan_mask;
                     channel   <= lowest_bit(chan_mask);
                     sample    <= 1'b1;
                     cnt_reg   <= '0;
                     state_reg <= SAMPLE;
                  end else begin
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state_reg <= IDLE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sar_adc_scan.sv
// Bench for sar_adc_scan: a comparator front-end model with per-channel inputs
// drives two instances (one and three sample cycles) and results are checked.
module tb_sar_adc_scan;
   logic       clk = 1'b0;
   logic       reset, start, continuous;
   logic [3:0] chan_mask;
   logic       comp, comp3;
   logic [1:0] comp_mode;            // 0: analogue model, 1: tied high, 2: tied low
   logic [5:0] vin [4];

   logic       sample, valid, busy, done;
   logic [1:0] channel, result_chan;
   logic [5:0] trial, result;
   logic       sample3, valid3, busy3, done3;
   logic [1:0] channel3, result_chan3;
   logic [5:0] trial3, result3;

   int vectors = 0;
   int miscompares = 0;

   // Monitor record of one scan
   int   obs_res[$];
   int   obs_chan[$];
   int   obs_cyc[$];
   int   samp_cnt;
   int   end_cyc;
   logic end_done;

   always #5 clk = ~clk;

   assign comp  = (comp_mode == 2'd1) ? 1'b1 : (comp_mode == 2'd2) ? 1'b0 : (trial  > vin[channel]);
   assign comp3 = (comp_mode == 2'd1) ? 1'b1 : (comp_mode == 2'd2) ? 1'b0 : (trial3 > vin[channel3]);

   sar_adc_scan #(.Bits(6), .ChanBits(2), .SampleCycles(1)) dut (
      .clk(clk), .reset(reset), .start(start), .continuous(continuous),
      .chan_mask(chan_mask), .comp(comp), .sample(sample), .channel(channel),
      .trial(trial), .result(result), .result_chan(result_chan),
      .valid(valid), .busy(busy), .done(done));

   sar_adc_scan #(.Bits(6), .ChanBits(2), .SampleCycles(3)) dut3 (
      .clk(clk), .reset(reset), .start(start), .continuous(continuous),
      .chan_mask(chan_mask), .comp(comp3), .sample(sample3), .channel(channel3),
      .trial(trial3), .result(result3), .result_chan(result_chan3),
      .valid(valid3), .busy(busy3), .done(done3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; continuous = 1'b0; chan_mask = 4'd0;
      tick();
      reset = 1'b0;
   endtask

   // Ideal SAR outcome for comparator "trial > vin" is vin itself; rails override.
   function automatic int model_code(input int v);
      if (comp_mode == 2'd1) return 0;
      if (comp_mode == 2'd2) return 63;
      return v;
   endfunction

   // Starts a scan and records every Valid until Busy drops; cycles count edges
   // after the accepting edge. Hooks alter inputs just before edge (hook+1).
   task automatic run_scan(input bit use3, input logic [3:0] m, input logic cont,
                           input int chg_cyc, input logic [3:0] chg_mask,
                           input int drop_cyc, input int restart_cyc, input int budget);
      obs_res.delete(); obs_chan.delete(); obs_cyc.delete();
      samp_cnt = 0; end_cyc = -1; end_done = 1'b0;
      chan_mask = m; continuous = cont; start = 1'b1;
      tick();
      start = 1'b0;
      if (use3 ? sample3 : sample) samp_cnt++;
      for (int c = 1; c <= budget; c++) begin
         if (c - 1 == chg_cyc) chan_mask = chg_mask;
         if (c - 1 == drop_cyc) continuous = 1'b0;
         start = (c - 1 == restart_cyc);
         tick();
         if (use3 ? valid3 : valid) begin
            obs_res.push_back(int'(use3 ? result3 : result));
            obs_chan.push_back(int'(use3 ? result_chan3 : result_chan));
            obs_cyc.push_back(c);
         end
         if (use3 ? sample3 : sample) samp_cnt++;
         if (!(use3 ? busy3 : busy)) begin
            end_cyc = c;
            end_done = use3 ? done3 : done;
            break;
         end
      end
      start = 1'b0; continuous = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; continuous = 1'b0; chan_mask = 4'd0; comp_mode = 2'd0;
      tick();
      vectors++;
      if ({sample, channel, trial, result, result_chan, valid, busy, done} !== 20'd0) begin
         miscompares++;
         $display("FAIL reset_outputs got %b expected all zero",
                  {sample, channel, trial, result, result_chan, valid, busy, done});
      end
      vectors++;
      if ({sample3, busy3, done3, valid3, trial3} !== 10'd0) begin
         miscompares++;
         $display("FAIL reset_outputs3 got %b expected all zero", {sample3, busy3, done3, valid3, trial3});
      end
      reset = 1'b0;
   endtask

   task automatic test_single_vin45();
      int code, cand;
      do_reset();
      vin[0] = 6'd45;
      chan_mask = 4'b0001; start = 1'b1;
      tick();
      start = 1'b0;
      vectors++;
      if ({sample, busy, done, channel, trial} !== {1'b1, 1'b1, 1'b0, 2'd0, 6'd0}) begin
         miscompares++;
         $display("FAIL accept_state got s=%b b=%b d=%b ch=%0d t=%0d expected s=1 b=1 d=0 ch=0 t=0",
                  sample, busy, done, channel, trial);
      end
      code = 0;
      for (int b = 5; b >= 0; b--) begin
         cand = code | (1 << b);
         tick();
         vectors++;
         if (trial !== 6'(cand) || sample !== 1'b0 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL trial_step%0d got trial=%0d sample=%b valid=%b expected trial=%0d sample=0 valid=0",
                     6 - b, trial, sample, valid, cand);
         end
         if (!(cand > 45)) code = cand;
      end
      tick();
      vectors++;
      if ({valid, result, result_chan, done, busy, trial} !== {1'b1, 6'd45, 2'd0, 1'b1, 1'b0, 6'd0}) begin
         miscompares++;
         $display("FAIL end_of_conv got v=%b r=%0d rc=%0d d=%b b=%b t=%0d expected v=1 r=45 rc=0 d=1 b=0 t=0",
                  valid, result, result_chan, done, busy, trial);
      end
      tick();
      vectors++;
      if ({valid, result, done} !== {1'b0, 6'd45, 1'b1}) begin
         miscompares++;
         $display("FAIL hold_after got v=%b r=%0d d=%b expected v=0 r=45 d=1", valid, result, done);
      end
   endtask

   task automatic test_rails();
      for (int k = 1; k <= 2; k++) begin
         do_reset();
         comp_mode = 2'(k);
         run_scan(1'b0, 4'b0001, 1'b0, -1, 4'd0, -1, -1, 30);
         vectors++;
         if (obs_res.size() != 1 || end_cyc != 7 || obs_cyc[0] != 7 || obs_res[0] != model_code(0)) begin
            miscompares++;
            $display("FAIL rail_mode%0d got n=%0d end=%0d res=%0d expected n=1 end=7 res=%0d",
                     k, obs_res.size(), end_cyc, (obs_res.size() > 0) ? obs_res[0] : -1, model_code(0));
         end
      end
      comp_mode = 2'd0;
   endtask

   task automatic test_two_channels();
      do_reset();
      vin[1] = 6'd10; vin[3] = 6'd50;
      run_scan(1'b0, 4'b1010, 1'b0, -1, 4'd0, -1, -1, 40);
      vectors++;
      if (obs_res.size() != 2 || end_cyc != 14 || end_done !== 1'b1) begin
         miscompares++;
         $display("FAIL two_ch_count got n=%0d end=%0d done=%b expected n=2 end=14 done=1",
                  obs_res.size(), end_cyc, end_done);
      end else begin
         vectors++;
         if (obs_res[0] != 10 || obs_chan[0] != 1 || obs_cyc[0] != 7 ||
             obs_res[1] != 50 || obs_chan[1] != 3 || obs_cyc[1] != 14) begin
            miscompares++;
            $display("FAIL two_ch_values got (%0d,%0d@%0d) (%0d,%0d@%0d) expected (10,1@7) (50,3@14)",
                     obs_res[0], obs_chan[0], obs_cyc[0], obs_res[1], obs_chan[1], obs_cyc[1]);
         end
      end
   endtask

   task automatic test_random_masks();
      int exp_chan[$];
      logic [3:0] m;
      for (int it = 0; it < 6; it++) begin
         do_reset();
         m = 4'($urandom_range(1, 15));
         for (int c = 0; c < 4; c++) vin[c] = 6'($urandom_range(0, 63));
         exp_chan.delete();
         for (int c = 0; c < 4; c++) if (m[c]) exp_chan.push_back(c);
         run_scan(1'b0, m, 1'b0, -1, 4'd0, -1, -1, 40);
         vectors++;
         if (obs_res.size() != exp_chan.size() || end_cyc != 7 * exp_chan.size() || end_done !== 1'b1) begin
            miscompares++;
            $display("FAIL rand_count mask=%b got n=%0d end=%0d done=%b expected n=%0d end=%0d done=1",
                     m, obs_res.size(), end_cyc, end_done, exp_chan.size(), 7 * exp_chan.size());
         end else begin
            for (int j = 0; j < exp_chan.size(); j++) begin
               vectors++;
               if (obs_chan[j] != exp_chan[j] || obs_res[j] != int'(vin[exp_chan[j]]) || obs_cyc[j] != 7 * (j + 1)) begin
                  miscompares++;
                  $display("FAIL rand_result mask=%b idx=%0d got (%0d,%0d@%0d) expected (%0d,%0d@%0d)",
                           m, j, obs_res[j], obs_chan[j], obs_cyc[j],
                           int'(vin[exp_chan[j]]), exp_chan[j], 7 * (j + 1));
               end
            end
         end
      end
   endtask

   task automatic test_continuous();
      int ec[3] = '{1, 2, 3};
      do_reset();
      for (int c = 0; c < 4; c++) vin[c] = 6'($urandom_range(0, 63));
      // Mask shrinks to channel 3 during channel 1; continuous drops during pass 2.
      run_scan(1'b0, 4'b0110, 1'b1, 3, 4'b1000, 17, -1, 60);
      vectors++;
      if (obs_res.size() != 3 || end_cyc != 21 || end_done !== 1'b1) begin
         miscompares++;
         $display("FAIL cont_count got n=%0d end=%0d done=%b expected n=3 end=21 done=1",
                  obs_res.size(), end_cyc, end_done);
      end else begin
         for (int j = 0; j < 3; j++) begin
            vectors++;
            if (obs_chan[j] != ec[j] || obs_res[j] != int'(vin[ec[j]]) || obs_cyc[j] != 7 * (j + 1)) begin
               miscompares++;
               $display("FAIL cont_result idx=%0d got (%0d,%0d@%0d) expected (%0d,%0d@%0d)",
                        j, obs_res[j], obs_chan[j], obs_cyc[j], int'(vin[ec[j]]), ec[j], 7 * (j + 1));
            end
         end
      end
   endtask

   task automatic test_sample3();
      do_reset();
      vin[0] = 6'($urandom_range(0, 63)); vin[1] = 6'($urandom_range(0, 63));
      run_scan(1'b1, 4'b0011, 1'b0, -1, 4'd0, -1, -1, 40);
      vectors++;
      if (samp_cnt != 6 || end_cyc != 18 || obs_res.size() != 2) begin
         miscompares++;
         $display("FAIL sample3_timing got samples=%0d end=%0d n=%0d expected samples=6 end=18 n=2",
                  samp_cnt, end_cyc, obs_res.size());
      end else begin
         vectors++;
         if (obs_cyc[0] != 9 || obs_res[0] != int'(vin[0]) || obs_chan[0] != 0 ||
             obs_cyc[1] != 18 || obs_res[1] != int'(vin[1]) || obs_chan[1] != 1) begin
            miscompares++;
            $display("FAIL sample3_values got (%0d,%0d@%0d) (%0d,%0d@%0d) expected (%0d,0@9) (%0d,1@18)",
                     obs_res[0], obs_chan[0], obs_cyc[0], obs_res[1], obs_chan[1], obs_cyc[1],
                     vin[0], vin[1]);
         end
      end
   endtask

   task automatic test_busy_start();
      do_reset();
      vin[0] = 6'($urandom_range(0, 63));
      // Start pulsed with a full mask while busy must change nothing.
      run_scan(1'b0, 4'b0001, 1'b0, 2, 4'b1111, -1, 2, 30);
      vectors++;
      if (obs_res.size() != 1 || end_cyc != 7 || obs_res[0] != int'(vin[0]) || obs_chan[0] != 0) begin
         miscompares++;
         $display("FAIL busy_start got n=%0d end=%0d res=%0d expected n=1 end=7 res=%0d",
                  obs_res.size(), end_cyc, (obs_res.size() > 0) ? obs_res[0] : -1, vin[0]);
      end
   endtask

   task automatic test_zero_mask();
      chan_mask = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      vectors++;
      if ({busy, done, sample, valid} !== 4'b0100) begin
         miscompares++;
         $display("FAIL zero_mask got busy=%b done=%b sample=%b valid=%b expected busy=0 done=1 sample=0 valid=0",
                  busy, done, sample, valid);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      vin[0] = 6'd45;
      run_scan(1'b0, 4'b0001, 1'b0, -1, 4'd0, -1, -1, 30);
      chan_mask = 4'b0001; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      vectors++;
      if ({sample, channel, trial, result, result_chan, valid, busy, done} !== 20'd0) begin
         miscompares++;
         $display("FAIL reset_mid got %b expected all zero",
                  {sample, channel, trial, result, result_chan, valid, busy, done});
      end
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         vectors++;
         if ({valid, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_mid_after cyc=%0d got v=%b b=%b d=%b expected 000", c, valid, busy, done);
         end
      end
   endtask

   initial begin
      comp_mode = 2'd0;
      for (int c = 0; c < 4; c++) vin[c] = 6'd0;
      test_reset();
      test_single_vin45();
      test_rails();
      test_two_channels();
      test_zero_mask();
      test_random_masks();
      test_continuous();
      test_sample3();
      test_busy_start();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
